// File: rtl/meta_retire_join.sv
// Purpose : join/retire side of the VLSU meta-info fork; retires issued tags in order once
//           both the sequential and shuffle paths have completed them.
// Latency : last done at edge N -> retire_valid_o in cycle N+1 (N+2 with output register).
// Backpr. : issue stalls when the tag FIFO is full; each done stalls until it has an
//           uncompleted entry to land on; retire_valid_o/retire_tag_o are held until retire_ready_i.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   issue_valid_i/ready_o/tag_i        record tag of an entry issued to seq+shf
//   seq_done_valid_i/ready_o           seq path completed its oldest uncompleted entry
//   shf_done_valid_i/ready_o           shf path completed its oldest uncompleted entry
//   retire_valid_o/ready_i/tag_o       in-order retire of fully completed entries
//   outstanding_o, idle_o              entries issued but not yet retired
//
// Optional feature macro META_RETIRE_OUT_REG_EN: adds a 1-entry output register
// (valid + tag) between the FIFO head and the retire port, keeping full throughput.

module meta_retire_join #(
    parameter int unsigned NrOutstanding = 4,
    parameter int unsigned TagWidth      = 4,
    localparam int unsigned CntW         = $clog2(NrOutstanding + 1),
    localparam int unsigned PtrW         = (NrOutstanding > 1) ? $clog2(NrOutstanding) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [TagWidth-1:0] issue_tag_i,
    input  logic                seq_done_valid_i,
    output logic                seq_done_ready_o,
    input  logic                shf_done_valid_i,
    output logic                shf_done_ready_o,
    output logic                retire_valid_o,
    input  logic                retire_ready_i,
    output logic [TagWidth-1:0] retire_tag_o,
    output logic [CntW-1:0]     outstanding_o,
    output logic                idle_o
);

    logic [TagWidth-1:0] tag_mem [NrOutstanding];
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [CntW-1:0]     occ;
    logic [CntW-1:0]     seq_cnt;
    logic [CntW-1:0]     shf_cnt;

    logic                issue_fire;
    logic                seq_fire;
    logic                shf_fire;
    logic                head_done;
    logic                pop;
    logic [TagWidth-1:0] head_tag;

    // All readies come from registered state only, so an issue and a done in the
    // same cycle never interact combinationally.
    assign issue_ready_o    = (occ != CntW'(NrOutstanding));
    assign seq_done_ready_o = (seq_cnt < occ);
    assign shf_done_ready_o = (shf_cnt < occ);

    assign issue_fire = issue_valid_i    && issue_ready_o;
    assign seq_fire   = seq_done_valid_i && seq_done_ready_o;
    assign shf_fire   = shf_done_valid_i && shf_done_ready_o;

    // Counters never exceed occ, so a non-zero count on both paths means the
    // FIFO head has been completed by both.
    assign head_done = (occ != '0) && (seq_cnt != '0) && (shf_cnt != '0);
    assign head_tag  = tag_mem[rd_ptr];

`ifdef META_RETIRE_OUT_REG_EN
    logic                out_vld;
    logic [TagWidth-1:0] out_tag;

    // Refill the output register whenever it is empty or draining this cycle.
    assign pop = head_done && (!out_vld || retire_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld <= 1'b0;
            out_tag <= '0;
        end else if (pop) begin
            out_vld <= 1'b1;
            out_tag <= head_tag;
        end else if (retire_ready_i) begin
            out_vld <= 1'b0;
        end
    end

    assign retire_valid_o = out_vld;
    assign retire_tag_o   = out_tag;
    assign outstanding_o  = occ + CntW'(out_vld);
`else
    assign pop            = head_done && retire_ready_i;
    // Tag is forced to zero while nothing is retiring so the port is clean at reset
    // without needing a reset on the tag storage.
    assign retire_valid_o = head_done;
    assign retire_tag_o   = head_done ? head_tag : '0;
    assign outstanding_o  = occ;
`endif

    assign idle_o = (outstanding_o == '0);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NrOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            seq_cnt <= '0;
            shf_cnt <= '0;
        end else begin
            if (issue_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)        rd_ptr <= ptr_inc(rd_ptr);
            occ     <= occ     + CntW'(issue_fire) - CntW'(pop);
            seq_cnt <= seq_cnt + CntW'(seq_fire)   - CntW'(pop);
            shf_cnt <= shf_cnt + CntW'(shf_fire)   - CntW'(pop);
        end
    end

    // Tag storage needs no reset: entries are only read once occ covers them.
    always_ff @(posedge clk_i) begin
        if (issue_fire) tag_mem[wr_ptr] <= issue_tag_i;
    end

endmodule

// File: tb/tb_meta_retire_join.sv
module tb_meta_retire_join;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       issue_valid_i;
    logic       issue_ready_o;
    logic [3:0] issue_tag_i;
    logic       seq_done_valid_i;
    logic       seq_done_ready_o;
    logic       shf_done_valid_i;
    logic       shf_done_ready_o;
    logic       retire_valid_o;
    logic       retire_ready_i;
    logic [3:0] retire_tag_o;
    logic [2:0] outstanding_o;
    logic       idle_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    meta_retire_join #(
        .NrOutstanding(4),
        .TagWidth     (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_tag_i      (issue_tag_i),
        .seq_done_valid_i (seq_done_valid_i),
        .seq_done_ready_o (seq_done_ready_o),
        .shf_done_valid_i (shf_done_valid_i),
        .shf_done_ready_o (shf_done_ready_o),
        .retire_valid_o   (retire_valid_o),
        .retire_ready_i   (retire_ready_i),
        .retire_tag_o     (retire_tag_o),
        .outstanding_o    (outstanding_o),
        .idle_o           (idle_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".issue_rdy"}, 32'(issue_ready_o),    1);
        chk({tag, ".seq_rdy"},   32'(seq_done_ready_o), 0);
        chk({tag, ".shf_rdy"},   32'(shf_done_ready_o), 0);
        chk({tag, ".ret_vld"},   32'(retire_valid_o),   0);
        chk({tag, ".ret_tag"},   32'(retire_tag_o),     0);
        chk({tag, ".outst"},     32'(outstanding_o),    0);
        chk({tag, ".idle"},      32'(idle_o),           1);
    endtask

    initial begin
        rst_ni           = 1'b0;
        issue_valid_i    = 1'b0;
        issue_tag_i      = 4'd0;
        seq_done_valid_i = 1'b0;
        shf_done_valid_i = 1'b0;
        retire_ready_i   = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst_ni = 1'b1;
        step();

        // ---- T1: tag 3; seq done offered together with the first issue (stalled)
        issue_valid_i = 1'b1; issue_tag_i = 4'd3; seq_done_valid_i = 1'b1;
        step();
        issue_valid_i = 1'b0;
        chk("t1.outst1",    32'(outstanding_o),    1);
        chk("t1.seq_rdy",   32'(seq_done_ready_o), 1);
        chk("t1.no_ret0",   32'(retire_valid_o),   0);
        step();                       // seq done fires here
        seq_done_valid_i = 1'b0;
        chk("t1.seq_full",  32'(seq_done_ready_o), 0);
        chk("t1.shf_rdy",   32'(shf_done_ready_o), 1);
        chk("t1.no_ret1",   32'(retire_valid_o),   0);
        step();
        shf_done_valid_i = 1'b1;
        step();                       // shf done fires; retire visible next cycle
        shf_done_valid_i = 1'b0;
        chk("t1.ret_vld",   32'(retire_valid_o),   1);
        chk("t1.ret_tag",   32'(retire_tag_o),     3);
        chk("t1.shf_full",  32'(shf_done_ready_o), 0);
        retire_ready_i = 1'b1;
        step();
        chk("t1.idle",      32'(idle_o),           1);
        chk("t1.ret_gone",  32'(retire_valid_o),   0);
        chk("t1.outst0",    32'(outstanding_o),    0);

        // ---- T2: tag 5; shf completes before seq
        issue_valid_i = 1'b1; issue_tag_i = 4'd5;
        step();
        issue_valid_i = 1'b0; shf_done_valid_i = 1'b1;
        step();
        shf_done_valid_i = 1'b0;
        chk("t2.no_ret",    32'(retire_valid_o),   0);
        chk("t2.shf_full",  32'(shf_done_ready_o), 0);
        seq_done_valid_i = 1'b1;
        step();
        seq_done_valid_i = 1'b0;
        chk("t2.ret_vld",   32'(retire_valid_o),   1);
        chk("t2.ret_tag",   32'(retire_tag_o),     5);
        step();
        chk("t2.idle",      32'(idle_o),           1);
        chk("t2.once",      32'(retire_valid_o),   0);

        // ---- T3: fill with tags 0..3, all seq dones, then shf dones drain in order
        for (int i = 0; i < 4; i++) begin
            issue_valid_i = 1'b1; issue_tag_i = 4'(i);
            step();
        end
        chk("t3.full_rdy",  32'(issue_ready_o),    0);
        chk("t3.outst4",    32'(outstanding_o),    4);
        issue_tag_i = 4'd9;           // push attempt while full must be ignored
        step();
        issue_valid_i = 1'b0;
        chk("t3.push_full", 32'(outstanding_o),    4);
        seq_done_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t3.seq_rdy0",  32'(seq_done_ready_o), 0);
        chk("t3.no_ret",    32'(retire_valid_o),   0);
        step();                       // extra seq done refused
        seq_done_valid_i = 1'b0;
        chk("t3.seq_rdy0b", 32'(seq_done_ready_o), 0);
        shf_done_valid_i = 1'b1;
        step();
        chk("t3.ret0_vld",  32'(retire_valid_o),   1);
        chk("t3.ret0_tag",  32'(retire_tag_o),     0);
        step();
        chk("t3.ret1_vld",  32'(retire_valid_o),   1);
        chk("t3.ret1_tag",  32'(retire_tag_o),     1);
        step();
        chk("t3.ret2_vld",  32'(retire_valid_o),   1);
        chk("t3.ret2_tag",  32'(retire_tag_o),     2);
        step();
        shf_done_valid_i = 1'b0;
        chk("t3.ret3_vld",  32'(retire_valid_o),   1);
        chk("t3.ret3_tag",  32'(retire_tag_o),     3);
        chk("t3.outst1",    32'(outstanding_o),    1);
        step();
        chk("t3.idle",      32'(idle_o),           1);

        // ---- T4: complete head held for 10 cycles without retire_ready_i
        retire_ready_i = 1'b0;
        issue_valid_i = 1'b1; issue_tag_i = 4'hA;
        step();
        issue_valid_i = 1'b0; seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        step();
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t4.hold_vld",   32'(retire_valid_o), 1);
            chk("t4.hold_tag",   32'(retire_tag_o),   32'hA);
            chk("t4.hold_outst", 32'(outstanding_o),  1);
            step();
        end
        retire_ready_i = 1'b1;
        step();
        chk("t4.idle",      32'(idle_o),           1);

        // ---- T5: issue + seq + shf + retire all in one cycle at occ=2
        retire_ready_i = 1'b0;
        issue_valid_i = 1'b1; issue_tag_i = 4'd6;
        step();
        issue_tag_i = 4'd7;
        step();
        issue_valid_i = 1'b0; seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        step();
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        chk("t5.pre_outst", 32'(outstanding_o),    2);
        chk("t5.pre_tag",   32'(retire_tag_o),     6);
        issue_valid_i = 1'b1; issue_tag_i = 4'd8;
        seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1; retire_ready_i = 1'b1;
        step();
        issue_valid_i = 1'b0; seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        chk("t5.outst2",    32'(outstanding_o),    2);
        chk("t5.ret_vld",   32'(retire_valid_o),   1);
        chk("t5.ret_tag",   32'(retire_tag_o),     7);
        chk("t5.seq_rdy",   32'(seq_done_ready_o), 1);
        chk("t5.shf_rdy",   32'(shf_done_ready_o), 1);
        step();                       // tag 7 retires; counts drop to 0
        chk("t5.outst1",    32'(outstanding_o),    1);
        chk("t5.no_ret",    32'(retire_valid_o),   0);
        seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        step();
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        chk("t5.ret8_tag",  32'(retire_tag_o),     8);
        step();
        chk("t5.idle",      32'(idle_o),           1);

        // ---- T6: dones while FIFO empty are refused
        seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        step();
        step();
        chk("t6.seq_rdy",   32'(seq_done_ready_o), 0);
        chk("t6.shf_rdy",   32'(shf_done_ready_o), 0);
        chk("t6.no_ret",    32'(retire_valid_o),   0);
        chk("t6.outst",     32'(outstanding_o),    0);
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        // a later entry must still need both dones (no phantom counts)
        issue_valid_i = 1'b1; issue_tag_i = 4'd4;
        step();
        issue_valid_i = 1'b0;
        step();
        chk("t6.no_phantom", 32'(retire_valid_o),  0);
        seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        step();
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        step();
        chk("t6.idle",      32'(idle_o),           1);

        // ---- T7: reset with 2 outstanding entries
        issue_valid_i = 1'b1; issue_tag_i = 4'd1;
        step();
        issue_tag_i = 4'd2;
        step();
        issue_valid_i = 1'b0; seq_done_valid_i = 1'b1; shf_done_valid_i = 1'b1;
        retire_ready_i = 1'b0;
        step();
        seq_done_valid_i = 1'b0; shf_done_valid_i = 1'b0;
        chk("t7.pre_outst", 32'(outstanding_o),    2);
        chk("t7.pre_vld",   32'(retire_valid_o),   1);
        #2 rst_ni = 1'b0;
        #1;
        chk_reset_vals("t7.async");
        step();
        rst_ni = 1'b1;
        retire_ready_i = 1'b1;
        step();
        step();
        chk_reset_vals("t7.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
